apb_master_arb: RTL and testbench

Two-port APB master with round-robin arbitration. It accepts simple valid/ack transfer requests from two on-chip requesters and sequences each one as an APB3 SETUP/ACCESS transfer toward the existing `APB_SLAVE`. It returns read data and error status to the requester that issued the transfer, and aborts any transfer that exceeds a programmable PREADY timeout. It sits between the requesters and the APB bus, and is the only APB master on that bus.

---
 rtl/apb_master_arb.sv | 193 +++++++++++++++++++
 tb/tb_apb_master_arb.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester APB3 master with round-robin arbitration.
// Each requester hands over a valid/ack request. The winner is sequenced as an
// APB SETUP/ACCESS transfer. Read data and error status go back with a
// one-cycle done pulse. A programmable PREADY timeout aborts a stalled transfer.
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   reqN_valid/write/addr/wdata   request from requester N (N = 0, 1)
//   reqN_ack             pulse: request captured
//   reqN_done            pulse: transfer finished; reqN_rdata / reqN_err valid
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB master outputs
//   PRDATA/PREADY/PSLVERR              APB slave responses
module apb_master_arb #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic [1:0]        PSLVERR
);

    localparam int unsigned CNT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_q;
    logic                owner_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                ack0_q;
    logic                ack1_q;
    logic                done0_q;
    logic                done1_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                err0_q;
    logic                err1_q;

    logic                any_req_c;
    logic                pick1_c;
    logic                win_write_c;
    logic [ADDR_W-1:0]   win_addr_c;
    logic [DATA_W-1:0]   win_wdata_c;
    logic                timeout_c;
    logic                abort_c;
    logic                xfer_ok_c;
    logic                grant_c;

    // Round-robin pick: on a tie the port not served last wins.
    always_comb begin
        any_req_c   = req0_valid | req1_valid;
        pick1_c     = req1_valid & (~req0_valid | ~last_q);
        win_write_c = pick1_c ? req1_write : req0_write;
        win_addr_c  = pick1_c ? req1_addr  : req0_addr;
        win_wdata_c = pick1_c ? req1_wdata : req0_wdata;
        timeout_c   = (TIMEOUT != 32'd0) && (cnt_q == CNT_W'(TIMEOUT));
        abort_c     = (state_q == ACCESS) && timeout_c;
        xfer_ok_c   = (state_q == ACCESS) && !timeout_c && PREADY;
        // Grants happen from IDLE or straight out of a completed ACCESS (back-to-back).
        grant_c     = any_req_c && ((state_q == IDLE) || xfer_ok_c);
    end

    // Transfer sequencer with registered APB and requester outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;

            // Completion or abort: report to the port that owns the transfer.
            if (abort_c || xfer_ok_c) begin
                if (owner_q) begin
                    done1_q <= 1'b1;
                    err1_q  <= abort_c | (|PSLVERR);
                    if (abort_c) begin
                        rdata1_q <= '0;
                    end else if (!pwrite_q) begin
                        rdata1_q <= PRDATA;
                    end
                end else begin
                    done0_q <= 1'b1;
                    err0_q  <= abort_c | (|PSLVERR);
                    if (abort_c) begin
                        rdata0_q <= '0;
                    end else if (!pwrite_q) begin
                        rdata0_q <= PRDATA;
                    end
                end
            end

            if (grant_c) begin
                state_q   <= SETUP;
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                pwrite_q  <= win_write_c;
                paddr_q   <= win_addr_c;
                pwdata_q  <= win_wdata_c;
                owner_q   <= pick1_c;
                last_q    <= pick1_c;
                ack0_q    <= ~pick1_c;
                ack1_q    <= pick1_c;
            end else begin
                case (state_q)
                    SETUP: begin
                        state_q   <= ACCESS;
                        penable_q <= 1'b1;
                        cnt_q     <= '0;
                    end
                    ACCESS: begin
                        if (abort_c || xfer_ok_c) begin
                            state_q   <= IDLE;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                        end else if (TIMEOUT != 32'd0) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign req0_ack   = ack0_q;
    assign req1_ack   = ack1_q;
    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: directed scenarios plus randomized two-port traffic against
// a transaction-level memory model; the bench also plays the APB slave.
module tb_apb_master_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req0_valid, req0_write, req0_ack, req0_done, req0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_write, req1_ack, req1_done, req1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic          PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [1:0]    PSLVERR;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    bit   force_low = 1'b0;
    bit   rand_wait = 1'b0;
    int   fixed_wait = 0;
    int   wait_cnt = 0;
    int   cur_wait = 0;
    logic unmapped;

    always #5 PCLK = ~PCLK;

    apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ack(req0_ack), .req0_done(req0_done),
        .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ack(req1_ack), .req1_done(req1_done),
        .req1_rdata(req1_rdata), .req1_err(req1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // APB slave: addresses with low bits set are unmapped and answer PSLVERR=01.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (force_low || wait_cnt < cur_wait) begin
                PREADY   = 1'b0;
                wait_cnt = wait_cnt + 1;
            end else begin
                PREADY   = 1'b1;
                unmapped = (PADDR[1:0] != 2'b00);
                PSLVERR  = unmapped ? 2'b01 : 2'b00;
                if (PWRITE) begin
                    if (!unmapped) slv_mem[PADDR] = PWDATA;
                    PRDATA = $urandom;
                end else begin
                    PRDATA = unmapped ? 32'hBADBAD00 :
                             (slv_mem.exists(PADDR) ? slv_mem[PADDR] : 32'h0);
                end
            end
        end else begin
            PREADY   = 1'b0;
            PSLVERR  = 2'($urandom);
            PRDATA   = $urandom;
            wait_cnt = 0;
            cur_wait = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
        end
    end

    task automatic set_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge PCLK);
        total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin bad++; $display("FAIL reset_psel_penable: got %b%b want 00", PSEL, PENABLE); end
        total++; if ({req1_ack, req0_ack, req1_done, req0_done} !== 4'b0) begin bad++; $display("FAIL reset_ack_done: got %b want 0000", {req1_ack, req0_ack, req1_done, req0_done}); end
        total++; if (req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h %h want 0 0", req0_rdata, req1_rdata); end
        total++; if ({req1_err, req0_err, PWRITE} !== 3'b0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin bad++; $display("FAIL reset_bus: got err=%b%b pw=%b pa=%h pd=%h want zeros", req1_err, req0_err, PWRITE, PADDR, PWDATA); end
        PRESETn = 1'b1;
        @(negedge PCLK);
        total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL idle_psel: got %b want 0", PSEL); end
    endtask

    task automatic test_single_write();
        int done_at = -1;
        set_req(0, 1'b1, 32'h40000004, 32'hDEADBEEF);
        for (int c = 1; c <= 6; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                total++; if ({req0_ack, PSEL, PENABLE, PWRITE} !== 4'b1101) begin bad++; $display("FAIL wr_setup_ctrl: got %b want 1101", {req0_ack, PSEL, PENABLE, PWRITE}); end
                total++; if (PADDR !== 32'h40000004 || PWDATA !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_setup_fields: got %h %h want 40000004 deadbeef", PADDR, PWDATA); end
                req0_valid = 1'b0;
            end
            if (c == 2) begin
                total++; if ({req0_ack, PSEL, PENABLE} !== 3'b011) begin bad++; $display("FAIL wr_access_ctrl: got %b want 011", {req0_ack, PSEL, PENABLE}); end
                total++; if (PADDR !== 32'h40000004 || PWDATA !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_access_fields: got %h %h want 40000004 deadbeef", PADDR, PWDATA); end
            end
            if (req0_done && done_at < 0) begin
                done_at = c;
                total++; if (req0_err !== 1'b0 || PSEL !== 1'b0) begin bad++; $display("FAIL wr_done_err_psel: got err=%b psel=%b want 0 0", req0_err, PSEL); end
            end
        end
        total++; if (done_at != 3) begin bad++; $display("FAIL wr_latency: got %0d want 3", done_at); end
    endtask

    task automatic test_read_wait();
        int done_at = -1;
        fixed_wait = 2;
        set_req(1, 1'b0, 32'h40000004, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                total++; if ({req1_ack, req0_ack} !== 2'b10) begin bad++; $display("FAIL rd_ack: got %b want 10", {req1_ack, req0_ack}); end
                req1_valid = 1'b0;
            end
            if (req1_done && done_at < 0) begin
                done_at = c;
                total++; if (req1_rdata !== 32'hDEADBEEF || req1_err !== 1'b0) begin bad++; $display("FAIL rd_data: got %h err=%b want deadbeef 0", req1_rdata, req1_err); end
            end
        end
        total++; if (done_at != 5) begin bad++; $display("FAIL rd_latency: got %0d want 5", done_at); end
        fixed_wait = 0;
    endtask

    task automatic test_contention();
        int n0 = 1;
        int n1 = 1;
        int prt;
        logic [1:0] ack_e, done_e;
        logic psel_e;
        logic [31:0] addr_e;
        set_req(0, 1'b1, 32'h40000100, 32'h00000A00);
        set_req(1, 1'b1, 32'h40000104, 32'h00000B00);
        for (int c = 1; c <= 9; c++) begin
            @(negedge PCLK);
            // Grants alternate 0,1,0,1 on odd cycles; each done lands 2 cycles after its grant.
            prt    = ((c - 1) / 2) % 2;
            ack_e  = (c % 2 == 1 && c <= 7) ? ((prt == 1) ? 2'b10 : 2'b01) : 2'b00;
            done_e = (c % 2 == 1 && c >= 3) ? ((prt == 1) ? 2'b01 : 2'b10) : 2'b00;
            psel_e = (c <= 8);
            addr_e = 32'h40000100 + 32'(4 * (c - 1) / 2);
            total++; if ({req1_ack, req0_ack} !== ack_e) begin bad++; $display("FAIL cont_ack c%0d: got %b want %b", c, {req1_ack, req0_ack}, ack_e); end
            total++; if ({req1_done, req0_done} !== done_e) begin bad++; $display("FAIL cont_done c%0d: got %b want %b", c, {req1_done, req0_done}, done_e); end
            total++; if (PSEL !== psel_e) begin bad++; $display("FAIL cont_psel c%0d: got %b want %b", c, PSEL, psel_e); end
            if (ack_e != 2'b00) begin
                total++; if (PADDR !== addr_e) begin bad++; $display("FAIL cont_addr c%0d: got %h want %h", c, PADDR, addr_e); end
            end
            if (req0_ack) begin
                if (n0 < 2) begin set_req(0, 1'b1, 32'h40000108, 32'h00000A01); n0++; end
                else req0_valid = 1'b0;
            end
            if (req1_ack) begin
                if (n1 < 2) begin set_req(1, 1'b1, 32'h4000010C, 32'h00000B01); n1++; end
                else req1_valid = 1'b0;
            end
        end
    endtask

    task automatic test_slave_error();
        int done_at = -1;
        set_req(0, 1'b1, 32'h40000006, 32'h12345678);
        for (int c = 1; c <= 5; c++) begin
            @(negedge PCLK);
            if (c == 1) req0_valid = 1'b0;
            if (req0_done && done_at < 0) begin
                done_at = c;
                total++; if (req0_err !== 1'b1) begin bad++; $display("FAIL slverr_err: got %b want 1", req0_err); end
            end
            if (c == 4) begin
                total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin bad++; $display("FAIL slverr_idle: got %b%b want 00", PSEL, PENABLE); end
            end
        end
        total++; if (done_at != 3) begin bad++; $display("FAIL slverr_latency: got %0d want 3", done_at); end
    endtask

    task automatic test_timeout();
        int done_at = -1;
        force_low = 1'b1;
        set_req(1, 1'b0, 32'h40000004, 32'h0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge PCLK);
            if (c == 1) req1_valid = 1'b0;
            if (c == 2) begin
                total++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin bad++; $display("FAIL to_access: got %b%b want 11", PSEL, PENABLE); end
            end
            if (done_at > 0 && c == done_at + 1) begin
                total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL to_psel_after: got %b want 0", PSEL); end
            end
            if (req1_done && done_at < 0) begin
                done_at = c;
                total++; if (req1_err !== 1'b1 || req1_rdata !== 32'h0) begin bad++; $display("FAIL to_status: got err=%b rdata=%h want 1 0", req1_err, req1_rdata); end
                total++; if (PSEL !== 1'b0) begin bad++; $display("FAIL to_psel: got %b want 0", PSEL); end
            end
        end
        // ACCESS is entered in cycle 2; done comes TIMEOUT+1 cycles later.
        total++; if (done_at != 2 + int'(TO) + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", done_at, 2 + int'(TO) + 1); end
        force_low = 1'b0;
    endtask

    task automatic test_reset_mid();
        int done_at = -1;
        bit saw_done0 = 1'b0;
        force_low = 1'b1;
        set_req(0, 1'b0, 32'h40000004, 32'h0);
        @(negedge PCLK);
        req0_valid = 1'b0;
        @(negedge PCLK);
        total++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin bad++; $display("FAIL rm_in_access: got %b%b want 11", PSEL, PENABLE); end
        set_req(1, 1'b0, 32'h40000004, 32'h0);
        #2 PRESETn = 1'b0;
        #1;
        total++; if ({PSEL, PENABLE, req1_ack, req0_ack, req1_done, req0_done} !== 6'b0) begin bad++; $display("FAIL rm_async: got %b want 000000", {PSEL, PENABLE, req1_ack, req0_ack, req1_done, req0_done}); end
        @(negedge PCLK);
        PRESETn   = 1'b1;
        force_low = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge PCLK);
            if (req0_done) saw_done0 = 1'b1;
            if (c == 1) begin
                total++; if ({req1_ack, req0_ack, PSEL} !== 3'b101) begin bad++; $display("FAIL rm_regrant: got %b want 101", {req1_ack, req0_ack, PSEL}); end
                req1_valid = 1'b0;
            end
            if (req1_done && done_at < 0) begin
                done_at = c;
                total++; if (req1_rdata !== 32'hDEADBEEF || req1_err !== 1'b0) begin bad++; $display("FAIL rm_data: got %h err=%b want deadbeef 0", req1_rdata, req1_err); end
            end
        end
        total++; if (done_at != 3) begin bad++; $display("FAIL rm_latency: got %0d want 3", done_at); end
        total++; if (saw_done0 !== 1'b0) begin bad++; $display("FAIL rm_no_done0: got %b want 0", saw_done0); end
    endtask

    task automatic drv(input int p);
        txn_t t;
        bit   got;
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge PCLK);
            t.w = 1'($urandom);
            t.a = 32'h40002000 | (32'($urandom_range(0, 7)) << 2) |
                  (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            t.d = $urandom;
            if (p == 0) q0.push_back(t); else q1.push_back(t);
            set_req(p, t.w, t.a, t.d);
            got = 1'b0;
            for (int k = 0; k < 80 && !got; k++) begin
                @(negedge PCLK);
                if ((p == 0) ? req0_ack : req1_ack) got = 1'b1;
            end
            total++; if (!got) begin bad++; $display("FAIL rnd_ack_timeout port%0d txn%0d: got no ack want ack", p, i); end
            if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        end
    endtask

    task automatic mon();
        int          got_n = 0;
        logic [31:0] setup_addr = 32'h0;
        logic [31:0] last_rd [2];
        txn_t        t;
        logic        err_e;
        logic        dn;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'hDEADBEEF;
        for (int c = 0; c < 4000 && got_n < 50; c++) begin
            @(negedge PCLK);
            if (PSEL && !PENABLE) setup_addr = PADDR;
            else if (PSEL && PENABLE) begin
                total++; if (PADDR !== setup_addr) begin bad++; $display("FAIL rnd_addr_stable: got %h want %h", PADDR, setup_addr); end
            end
            for (int p = 0; p < 2; p++) begin
                dn = (p == 0) ? req0_done : req1_done;
                if (dn) begin
                    got_n++;
                    total++;
                    if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                        bad++; $display("FAIL rnd_unexpected_done port%0d: got done want none", p);
                    end else begin
                        t = (p == 0) ? q0.pop_front() : q1.pop_front();
                        err_e = (t.a[1:0] != 2'b00);
                        if (!t.w) last_rd[p] = err_e ? 32'hBADBAD00 : (ref_mem.exists(t.a) ? ref_mem[t.a] : 32'h0);
                        else if (!err_e) ref_mem[t.a] = t.d;
                        if (((p == 0) ? req0_rdata : req1_rdata) !== last_rd[p] || ((p == 0) ? req0_err : req1_err) !== err_e) begin
                            bad++;
                            $display("FAIL rnd_resp port%0d addr %h: got %h/%b want %h/%b", p, t.a,
                                     (p == 0) ? req0_rdata : req1_rdata, (p == 0) ? req0_err : req1_err, last_rd[p], err_e);
                        end
                    end
                end
            end
        end
        total++; if (got_n != 50) begin bad++; $display("FAIL rnd_done_count: got %0d want 50", got_n); end
    endtask

    task automatic test_random();
        rand_wait = 1'b1;
        fork
            drv(0);
            drv(1);
            mon();
        join
        rand_wait = 1'b0;
    endtask

    initial begin
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 2'b00;
        PRESETn = 1'b1;
        #1 PRESETn = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_contention();
        test_slave_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
